button_event_classifier: RTL and testbench
==========================================

# button_event_classifier

Downstream consumer of the debounced button level produced by `top_debounced`. Converts the clean level into single-cycle event pulses: press, release, short click, double click, long press and auto-repeat while held. It lets UI logic (counters, mode selectors) act on gestures instead of raw levels. Timing thresholds are counted in clock cycles of the shared system clock.

## Interface

Parameters:
- `LONG_CYCLES`, default 100_000_000: hold time for a long press (1 s at 100 MHz).
- `DCLICK_CYCLES`, default 30_000_000: window after a release in which a second press counts as a double click.
- `REPEAT_CYCLES`, default 20_000_000: auto-repeat period after a long press.
- `CNT_BITS`, default 27: timer width. Must hold the largest of the three thresholds.

Ports:
- `clk` in 1: system clock, rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `debounced` in 1: clean, synchronous button level from the debouncer. 1 = pressed.
- `press_pulse` out 1: one-cycle pulse on every accepted press.
- `release_pulse` out 1: one-cycle pulse on every release.
- `short_click` out 1: one-cycle pulse for a single short press, emitted after the double-click window expires.
- `double_click` out 1: one-cycle pulse on release of the second short press.
- `long_press` out 1: one-cycle pulse when a hold reaches `LONG_CYCLES`.
- `repeat_pulse` out 1: one-cycle pulse every `REPEAT_CYCLES` while held after a long press.
- `held` out 1: registered copy of `debounced`.

## Operation

- **Edge detection.** `btn_q` is a register holding `debounced` from the previous edge.
  - rise = `debounced & ~btn_q`
  - fall = `~debounced & btn_q`
  - `held` = `btn_q`.
- **State machine.** States are IDLE, PRESSED, WAIT_SECOND, SECOND, LONG. One timer `cnt` (CNT_BITS wide) is cleared on every state change and increments by 1 each cycle otherwise. It saturates and never wraps.
- **IDLE**
  - rise → PRESSED, assert `press_pulse`.
- **PRESSED**
  - fall → WAIT_SECOND, assert `release_pulse`.
  - `cnt == LONG_CYCLES-1` with no fall → LONG, assert `long_press`.
- **WAIT_SECOND**
  - rise → SECOND, assert `press_pulse`.
  - `cnt == DCLICK_CYCLES-1` with no rise → IDLE, assert `short_click`.
- **SECOND**
  - fall → IDLE, assert `release_pulse` and `double_click`.
  - `cnt == LONG_CYCLES-1` → LONG, assert `long_press`. The pending first click is discarded: no `short_click`, no `double_click`.
- **LONG**
  - `cnt == REPEAT_CYCLES-1` → assert `repeat_pulse`, clear `cnt`, stay in LONG.
  - fall → IDLE, assert `release_pulse` only. No click event follows a long press.
- **Simultaneous events**
  - A fall on the same edge as the long threshold: the fall wins and the press is treated as short.
  - A rise on the same edge as the double-click timeout: the rise wins and a double click is in progress.
  - A fall on the same edge as a repeat tick: the fall wins and no `repeat_pulse` is asserted.
- All pulse outputs are registered and high for exactly one cycle. `short_click`, `double_click` and `long_press` are mutually exclusive per gesture.
- **Parameter legality:** every threshold ≥ 2 and < 2^CNT_BITS. Illegal values are not supported.

## Timing

- **Reset.** `reset_n` low forces, asynchronously: state IDLE, `cnt` = 0, `btn_q` = 0, and every output = 0, including `held`.
  - Reset mid-gesture drops the gesture with no pulses.
  - If `debounced` is high at reset release, the first edge sees a rise and a new press starts.
- **Output latency.** `debounced` rising before edge N → `press_pulse` high from edge N to N+1. `held` goes high at edge N.
- **Long press.** Press at edge N with the level held → `long_press` at edge N+LONG_CYCLES.
- **Short click.** Release at edge M with no re-press → `short_click` at edge M+DCLICK_CYCLES.
- **Repeat.** `long_press` at edge L → `repeat_pulse` at L+REPEAT_CYCLES, L+2·REPEAT_CYCLES, and so on until release.
- **Input rate.** Input changes are accepted every cycle. No handshake and no back-pressure.

## Test plan

All scenarios use LONG_CYCLES=20, DCLICK_CYCLES=10, REPEAT_CYCLES=5 and CNT_BITS=8.

- **Reset.** Hold `reset_n` low with `debounced`=1, then release → all outputs 0 during reset. `press_pulse` at the first edge after release. `held`=1.
- **Short click.** Press for 5 cycles, then release → `press_pulse`, then `release_pulse` 5 cycles later, then `short_click` exactly 10 cycles after the release. No other pulses.
- **Double click.** Press 3, release 4, press 3, release → two `press_pulse`, two `release_pulse`, and `double_click` coincident with the second `release_pulse`. No `short_click`.
- **Long press with repeat.** Hold for 32 cycles → `long_press` 20 cycles after `press_pulse`. `repeat_pulse` at +5 and +10 after it. `release_pulse` on release. No click pulse.
- **Boundaries.**
  - Release on the cycle the long threshold hits → short path, no `long_press`.
  - Re-press on the cycle the double-click window expires → double path, no `short_click`.
- **Reset mid-gesture.** Assert `reset_n` low during WAIT_SECOND → no `short_click`. State returns to IDLE and all outputs are 0 immediately.

Source files
------------

// File: rtl/button_event_classifier.sv
// Turns a debounced button level into one-cycle gesture pulses: press, release,
// short click, double click, long press and auto-repeat while held.
module button_event_classifier #(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int DCLICK_CYCLES = 30_000_000,
  parameter int REPEAT_CYCLES = 20_000_000,
  parameter int CNT_BITS      = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic debounced,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_WAIT_SECOND,
    ST_SECOND,
    ST_LONG
  } state_t;

  localparam logic [CNT_BITS-1:0] LONG_LAST   = CNT_BITS'(LONG_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] DCLICK_LAST = CNT_BITS'(DCLICK_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] REPEAT_LAST = CNT_BITS'(REPEAT_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX     = '1;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                btn_q;
  logic                rise, fall;
  logic                cnt_clr;
  logic                press_d, release_d, short_d, double_d, long_d, repeat_d;

  assign rise = debounced & ~btn_q;
  assign fall = ~debounced & btn_q;
  assign held = btn_q;

  // Each branch tests the edge before the timer, so an edge wins any tie
  // with a threshold expiring on the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          state_d   = ST_WAIT_SECOND;
          release_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
        end
      end
      ST_WAIT_SECOND: begin
        if (rise) begin
          state_d = ST_SECOND;
          press_d = 1'b1;
        end else if (cnt_q == DCLICK_LAST) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end
      ST_SECOND: begin
        if (fall) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          double_d  = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
        end
      end
      ST_LONG: begin
        if (fall) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_clr = 1'b1;
  end

  // Timer saturates rather than wrapping so an idle state never re-fires.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)               cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      btn_q         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_q         <= debounced;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      short_click   <= short_d;
      double_click  <= double_d;
      long_press    <= long_d;
      repeat_pulse  <= repeat_d;
    end
  end

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier: expected pulse events are queued
// with their edge number as stimulus is driven and matched as outputs appear.
module tb_button_event_classifier;

  localparam int LONG_C = 20;
  localparam int DCLK_C = 10;
  localparam int REP_C  = 5;

  localparam logic [5:0] EV_PRESS = 6'b100000;
  localparam logic [5:0] EV_REL   = 6'b010000;
  localparam logic [5:0] EV_SHORT = 6'b001000;
  localparam logic [5:0] EV_DBL   = 6'b000100;
  localparam logic [5:0] EV_LONG  = 6'b000010;
  localparam logic [5:0] EV_REP   = 6'b000001;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n;
  logic debounced;
  logic press_pulse, release_pulse, short_click, double_click;
  logic long_press, repeat_pulse, held;

  ev_t  q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   p, r;

  button_event_classifier #(
    .LONG_CYCLES  (LONG_C),
    .DCLICK_CYCLES(DCLK_C),
    .REPEAT_CYCLES(REP_C),
    .CNT_BITS     (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .debounced    (debounced),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_click  (short_click),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] outs();
    return {press_pulse, release_pulse, short_click, double_click, long_press, repeat_pulse};
  endfunction

  task automatic push(input int c, input logic [5:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: any pulse, or a due expected event, consumes one queue entry.
  always @(negedge clk) begin
    logic [5:0] v;
    ev_t        e;
    v = outs();
    if (v != 6'b0 || (q.size() > 0 && q[0].cyc <= cyc)) begin
      checks++;
      if (q.size() == 0) begin
        assert (v === 6'b0)
        else begin
          errors++;
          $error("FAIL unexpected_pulse cyc=%0d observed=%b expected=%b", cyc, v, 6'b0);
        end
      end else begin
        e = q.pop_front();
        assert (v === e.vec && cyc == e.cyc)
        else begin
          errors++;
          $error("FAIL event observed=%b@%0d expected=%b@%0d", v, cyc, e.vec, e.cyc);
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    debounced = 1'b1;
    tick(3);
    checks++;
    assert ({outs(), held} === 7'b0)
    else begin
      errors++;
      $error("FAIL reset_outputs observed=%b expected=%b", {outs(), held}, 7'b0);
    end

    // Level already high at reset release counts as a fresh press.
    push(cyc + 1, EV_PRESS);
    reset_n = 1'b1;
    tick(1);
    checks++;
    assert (held === 1'b1)
    else begin
      errors++;
      $error("FAIL held_after_reset observed=%b expected=%b", held, 1'b1);
    end
    tick(2);
    r = cyc + 1;
    debounced = 1'b0;
    push(r, EV_REL);
    push(r + DCLK_C, EV_SHORT);
    tick(15);

    // Short click
    p = cyc + 1;
    push(p, EV_PRESS);
    debounced = 1'b1;
    tick(5);
    debounced = 1'b0;
    push(p + 5, EV_REL);
    push(p + 5 + DCLK_C, EV_SHORT);
    tick(1);
    checks++;
    assert (held === 1'b0)
    else begin
      errors++;
      $error("FAIL held_after_release observed=%b expected=%b", held, 1'b0);
    end
    tick(15);

    // Double click
    p = cyc + 1;
    push(p, EV_PRESS);
    debounced = 1'b1;
    tick(3);
    debounced = 1'b0;
    push(p + 3, EV_REL);
    tick(4);
    debounced = 1'b1;
    push(p + 7, EV_PRESS);
    tick(3);
    debounced = 1'b0;
    push(p + 10, EV_REL | EV_DBL);
    tick(15);

    // Long press with two repeats
    p = cyc + 1;
    push(p, EV_PRESS);
    push(p + LONG_C, EV_LONG);
    push(p + LONG_C + REP_C, EV_REP);
    push(p + LONG_C + 2 * REP_C, EV_REP);
    debounced = 1'b1;
    tick(32);
    debounced = 1'b0;
    push(p + 32, EV_REL);
    tick(15);

    // Release on the long-threshold cycle stays a short click
    p = cyc + 1;
    push(p, EV_PRESS);
    debounced = 1'b1;
    tick(LONG_C);
    debounced = 1'b0;
    push(p + LONG_C, EV_REL);
    push(p + LONG_C + DCLK_C, EV_SHORT);
    tick(15);

    // Re-press on the double-click timeout cycle stays a double click
    p = cyc + 1;
    push(p, EV_PRESS);
    debounced = 1'b1;
    tick(2);
    r = cyc + 1;
    debounced = 1'b0;
    push(r, EV_REL);
    tick(DCLK_C);
    debounced = 1'b1;
    push(r + DCLK_C, EV_PRESS);
    tick(2);
    debounced = 1'b0;
    push(r + DCLK_C + 2, EV_REL | EV_DBL);
    tick(15);

    // Release on a repeat tick suppresses the repeat
    p = cyc + 1;
    push(p, EV_PRESS);
    push(p + LONG_C, EV_LONG);
    debounced = 1'b1;
    tick(LONG_C + REP_C);
    debounced = 1'b0;
    push(p + LONG_C + REP_C, EV_REL);
    tick(10);

    // Second press held to long discards the pending click
    p = cyc + 1;
    push(p, EV_PRESS);
    debounced = 1'b1;
    tick(2);
    debounced = 1'b0;
    push(p + 2, EV_REL);
    tick(3);
    debounced = 1'b1;
    push(p + 5, EV_PRESS);
    push(p + 5 + LONG_C, EV_LONG);
    tick(22);
    debounced = 1'b0;
    push(p + 27, EV_REL);
    tick(15);

    // Reset while in the double-click window
    p = cyc + 1;
    push(p, EV_PRESS);
    debounced = 1'b1;
    tick(3);
    debounced = 1'b0;
    tick(1);
    checks++;
    assert (release_pulse === 1'b1)
    else begin
      errors++;
      $error("FAIL release_before_reset observed=%b expected=%b", release_pulse, 1'b1);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    assert ({outs(), held} === 7'b0)
    else begin
      errors++;
      $error("FAIL async_reset_outputs observed=%b expected=%b", {outs(), held}, 7'b0);
    end
    tick(3);
    reset_n = 1'b1;
    tick(15);

    p = cyc + 1;
    push(p, EV_PRESS);
    debounced = 1'b1;
    tick(2);
    debounced = 1'b0;
    push(p + 2, EV_REL);
    push(p + 2 + DCLK_C, EV_SHORT);
    tick(15);

    checks++;
    assert (q.size() == 0)
    else begin
      errors++;
      $error("FAIL missing_events observed=%0d expected=%0d", q.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
